cr_huf_comp_sa_ob_arb: RTL and testbench

Frame-atomic round-robin arbiter that shares one outbound AXI4-stream master between several TLV producers in the Huffman compressor SA path. Each requester presents a FIFO-style outbound interface (empty/aempty/data/rd), as a TLV parser outbound port does. The arbiter grants one requester at a time and never interleaves beats of different frames. Granted beats go into a 2-entry output buffer, which presents the same FIFO-style interface to the downstream AXI4-stream master.

---
 rtl/cr_huf_comp_sa_ob_arb.sv | 177 +++++++++++++++++
 tb/tb_cr_huf_comp_sa_ob_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_huf_comp_sa_ob_arb.sv
// cr_huf_comp_sa_ob_arb
//   Frame-atomic round-robin arbiter. It shares one outbound stream between
//   N_REQ FIFO-style TLV producers. Once a requester is granted, only its beats
//   are popped, until its tlast beat has been taken. Granted beats land in a
//   2-entry output buffer that presents a FIFO-style interface downstream.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_empty/in_aempty per-requester FIFO status (aempty is informational)
//   in_data/in_tlast   per-requester head beat, requester i at [i*DW +: DW]
//   in_rd              per-requester pop strobe (one-hot or zero)
//   out_empty/aempty   output buffer holds 0 / at most 1 beat
//   out_data/out_tlast output buffer head beat
//   out_rd             downstream pop
//   frm_cnt            completed frames per requester, CNT_W bits each, wraps
//   rd_err             sticky: out_rd seen while the buffer was empty
//
// Handshake: both sides use FIFO-pop semantics. A beat transfers on a rising
// edge where the consumer's rd strobe is high and the producer's empty is low.
// in_rd is only raised when that holds. An out_rd against an empty buffer
// transfers nothing and is flagged in rd_err.
module cr_huf_comp_sa_ob_arb #(
  parameter int N_REQ = 2,
  parameter int DW    = 64,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       in_empty,
  input  logic [N_REQ-1:0]       in_aempty,
  input  logic [N_REQ*DW-1:0]    in_data,
  input  logic [N_REQ-1:0]       in_tlast,
  output logic [N_REQ-1:0]       in_rd,
  output logic                   out_empty,
  output logic                   out_aempty,
  output logic [DW-1:0]          out_data,
  output logic                   out_tlast,
  input  logic                   out_rd,
  output logic [N_REQ*CNT_W-1:0] frm_cnt,
  output logic                   rd_err
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t         state;
  logic [GW-1:0]  gnt;
  logic [GW-1:0]  rr;
  logic [GW-1:0]  rr_next;
  logic [GW-1:0]  scan_idx;
  logic           scan_hit;
  logic           gnt_empty;
  logic [DW:0]    beat;       // {tlast, data} of the granted requester's head
  logic           pop_in;
  logic           buf_pop;
  logic           frm_done;
  logic [DW:0]    buf0;       // buffer head, {tlast, data}
  logic [DW:0]    buf1;
  logic [1:0]     count;

  // Almost-empty plays no part in arbitration.
  logic unused_aempty;
  assign unused_aempty = ^in_aempty;

  // Round-robin scan: the first non-empty requester at or after rr, wrapping.
  always_comb begin
    logic [GW:0] sum;
    scan_hit = 1'b0;
    scan_idx = rr;
    sum      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_REQ)) sum = sum - (GW+1)'(N_REQ);
      if (!scan_hit && !in_empty[sum[GW-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = sum[GW-1:0];
      end
    end
  end

  // Head beat and empty flag of the granted requester.
  always_comb begin
    beat      = '0;
    gnt_empty = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt == GW'(i)) begin
        beat      = {in_tlast[i], in_data[i*DW +: DW]};
        gnt_empty = in_empty[i];
      end
    end
  end

  // A pop needs buffer room. A full buffer still accepts a beat when the
  // downstream drains one on the same edge.
  assign pop_in   = (state == XFER) && !gnt_empty && ((count != 2'd2) || out_rd);
  assign buf_pop  = out_rd && (count != 2'd0);
  assign frm_done = pop_in && beat[DW];
  assign rr_next  = (gnt == GW'(N_REQ-1)) ? '0 : gnt + 1'b1;
  assign in_rd    = pop_in ? (N_REQ'(1) << gnt) : '0;

  // Arbitration FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      rr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_hit) begin
            gnt   <= scan_idx;
            state <= XFER;
          end
        end
        XFER: begin
          if (frm_done) begin
            rr    <= rr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry output buffer. buf0 is always the head. On push plus pop at
  // count 2, the old buf1 moves forward and the new beat takes buf1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0   <= '0;
      buf1   <= '0;
      count  <= 2'd0;
      rd_err <= 1'b0;
    end else begin
      if (out_rd && (count == 2'd0)) rd_err <= 1'b1;
      case ({pop_in, buf_pop})
        2'b10: begin
          if (count == 2'd0) buf0 <= beat;
          else               buf1 <= beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          buf0  <= buf1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            buf0 <= beat;
          end else begin
            buf0 <= buf1;
            buf1 <= beat;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-requester completed-frame counters; wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (frm_done && (gnt == GW'(i)))
          frm_cnt[i*CNT_W +: CNT_W] <= frm_cnt[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

  assign out_empty  = (count == 2'd0);
  assign out_aempty = (count != 2'd2);
  assign out_data   = buf0[DW-1:0];
  assign out_tlast  = buf0[DW];

endmodule

// File: tb/tb_cr_huf_comp_sa_ob_arb.sv
// Bench for cr_huf_comp_sa_ob_arb. Behavioural model: per-requester source
// FIFOs, an expected output queue and a frame-level grant tracker, checked
// every cycle on the falling edge. Directed scenarios add literal checks.
module tb_cr_huf_comp_sa_ob_arb;
  localparam int N_REQ = 2;
  localparam int DW    = 16;
  localparam int CNT_W = 4;
  localparam int SRC_D = 256;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       in_empty;
  logic [N_REQ-1:0]       in_aempty;
  logic [N_REQ*DW-1:0]    in_data;
  logic [N_REQ-1:0]       in_tlast;
  logic [N_REQ-1:0]       in_rd;
  logic                   out_empty;
  logic                   out_aempty;
  logic [DW-1:0]          out_data;
  logic                   out_tlast;
  logic                   out_rd;
  logic [N_REQ*CNT_W-1:0] frm_cnt;
  logic                   rd_err;

  cr_huf_comp_sa_ob_arb #(.N_REQ(N_REQ), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_empty(in_empty), .in_aempty(in_aempty), .in_data(in_data),
    .in_tlast(in_tlast), .in_rd(in_rd),
    .out_empty(out_empty), .out_aempty(out_aempty), .out_data(out_data),
    .out_tlast(out_tlast), .out_rd(out_rd),
    .frm_cnt(frm_cnt), .rd_err(rd_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- sources ----------------
  logic [DW:0]      src_mem [N_REQ][SRC_D];
  int               src_hd [N_REQ];
  int               src_tl [N_REQ];
  logic [N_REQ-1:0] hold;
  logic [N_REQ-1:0] rd_cap;
  logic [DW:0]      out_log[$];

  task automatic reset_src();
    for (int i = 0; i < N_REQ; i++) begin
      src_hd[i] = 0;
      src_tl[i] = 0;
    end
  endtask

  // Beat data = {tag, beat index}; tlast on the final beat.
  task automatic add_frame(input int r, input int n, input logic [7:0] tag);
    for (int k = 0; k < n; k++) begin
      src_mem[r][src_tl[r]] = {(k == n-1), tag, 8'(k)};
      src_tl[r]++;
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N_REQ; i++) begin
      in_empty[i] = hold[i] || (src_hd[i] == src_tl[i]);
      if (src_hd[i] != src_tl[i]) begin
        in_data[i*DW +: DW] = src_mem[i][src_hd[i]][DW-1:0];
        in_tlast[i]         = src_mem[i][src_hd[i]][DW];
      end else begin
        in_data[i*DW +: DW] = '0;
        in_tlast[i]         = 1'b0;
      end
    end
    in_aempty = in_empty;
  endtask

  function automatic bit src_busy();
    for (int i = 0; i < N_REQ; i++)
      if (src_hd[i] != src_tl[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sources pop what the DUT strobed, then inputs are re-driven.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++)
      if (rd_cap[i] && (src_hd[i] != src_tl[i])) src_hd[i]++;
    refresh();
  endtask

  task automatic drain(input int max, output int cyc);
    cyc = 0;
    while ((src_busy() || !out_empty) && (cyc < max)) begin
      tick();
      cyc++;
    end
    if (cyc >= max) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", cyc);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    out_rd = 1'b0;
    hold   = '0;
    reset_src();
    refresh();
    tick();
    tick();
    rst = 1'b0;
    refresh();
    out_log.delete();
  endtask

  // ---------------- model + scoreboard ----------------
  logic [DW:0]      exp_q[$];
  bit               m_busy;
  int               m_gnt;
  int               m_rr;
  logic [CNT_W-1:0] m_frm [N_REQ];
  bit               m_err;
  bit               m_pop;
  logic [N_REQ-1:0] e_rd;
  logic [DW:0]      m_beat;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_gnt  = 0;
      m_rr   = 0;
      m_err  = 1'b0;
      for (int i = 0; i < N_REQ; i++) m_frm[i] = '0;
      rd_cap = '0;
    end else begin
      m_pop = m_busy && !in_empty[m_gnt] && ((exp_q.size() < 2) || out_rd);
      e_rd  = '0;
      if (m_pop) e_rd[m_gnt] = 1'b1;
      check("in_rd", 64'(in_rd), 64'(e_rd));
      check("out_empty", 64'(out_empty), 64'(exp_q.size() == 0));
      check("out_aempty", 64'(out_aempty), 64'(exp_q.size() <= 1));
      if (exp_q.size() > 0) begin
        check("out_data", 64'(out_data), 64'(exp_q[0][DW-1:0]));
        check("out_tlast", 64'(out_tlast), 64'(exp_q[0][DW]));
      end
      for (int i = 0; i < N_REQ; i++)
        check("frm_cnt", 64'(frm_cnt[i*CNT_W +: CNT_W]), 64'(m_frm[i]));
      check("rd_err", 64'(rd_err), 64'(m_err));
      rd_cap = in_rd;
      if (out_rd && !out_empty) out_log.push_back({out_tlast, out_data});
      // advance the model to the state after the coming rising edge
      if (out_rd) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else m_err = 1'b1;
      end
      if (m_pop) begin
        m_beat = {in_tlast[m_gnt], in_data[m_gnt*DW +: DW]};
        exp_q.push_back(m_beat);
        if (m_beat[DW]) begin
          m_frm[m_gnt] = m_frm[m_gnt] + 1'b1;
          m_rr   = (m_gnt + 1) % N_REQ;
          m_busy = 1'b0;
        end
      end else if (!m_busy) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (!m_busy && !in_empty[(m_rr + k) % N_REQ]) begin
            m_gnt  = (m_rr + k) % N_REQ;
            m_busy = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  int cyc;

  initial begin
    out_rd = 1'b0;
    hold   = '0;
    reset_src();
    refresh();
    tick();
    tick();
    // reset state, held in reset
    check("rst_out_empty", 64'(out_empty), 64'(1));
    check("rst_out_aempty", 64'(out_aempty), 64'(1));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_tlast", 64'(out_tlast), 64'(0));
    check("rst_in_rd", 64'(in_rd), 64'(0));
    check("rst_frm_cnt", 64'(frm_cnt), 64'(0));
    check("rst_rd_err", 64'(rd_err), 64'(0));
    rst = 1'b0;
    refresh();

    // 1: single requester, 3-beat frame, downstream always popping
    out_log.delete();
    add_frame(0, 3, 8'h10);
    out_rd = 1'b1;
    refresh();
    tick();
    check("t1_rd_c1", 64'(in_rd), 64'h1);
    tick();
    check("t1_rd_c2", 64'(in_rd), 64'h1);
    check("t1_data_d0", 64'(out_data), 64'h1000);
    tick();
    check("t1_rd_c3", 64'(in_rd), 64'h1);
    check("t1_data_d1", 64'(out_data), 64'h1001);
    tick();
    check("t1_rd_done", 64'(in_rd), 64'h0);
    check("t1_data_d2", 64'(out_data), 64'h1002);
    check("t1_tlast", 64'(out_tlast), 64'h1);
    check("t1_frm0", 64'(frm_cnt[CNT_W-1:0]), 64'h1);
    drain(20, cyc);
    check("t1_log_n", 64'(out_log.size()), 64'd3);
    check("t1_log2", 64'(out_log[2]), 64'h11002);

    // 2: both requesters busy with 2-beat frames -> 0,1,0,1, one idle gap each
    do_reset();
    add_frame(0, 2, 8'h20);
    add_frame(1, 2, 8'h30);
    add_frame(0, 2, 8'h21);
    add_frame(1, 2, 8'h31);
    out_rd = 1'b1;
    refresh();
    drain(60, cyc);
    check("t2_cycles", 64'(cyc), 64'd13);
    check("t2_log_n", 64'(out_log.size()), 64'd8);
    check("t2_log0", 64'(out_log[0]), 64'h02000);
    check("t2_log1", 64'(out_log[1]), 64'h12001);
    check("t2_log2", 64'(out_log[2]), 64'h03000);
    check("t2_log3", 64'(out_log[3]), 64'h13001);
    check("t2_log4", 64'(out_log[4]), 64'h02100);
    check("t2_log7", 64'(out_log[7]), 64'h13101);
    check("t2_frm", 64'(frm_cnt), 64'h22);

    // 3: back-pressure on a 4-beat frame
    out_log.delete();
    out_rd = 1'b0;
    add_frame(0, 4, 8'h40);
    refresh();
    tick();
    tick();
    tick();
    check("t3_stall_rd", 64'(in_rd), 64'h0);
    check("t3_full_aempty", 64'(out_aempty), 64'h0);
    check("t3_head", 64'(out_data), 64'h4000);
    tick();
    check("t3_stall_rd2", 64'(in_rd), 64'h0);
    out_rd = 1'b1;
    refresh();
    #1;
    check("t3_resume_rd", 64'(in_rd), 64'h1);
    drain(20, cyc);
    check("t3_log_n", 64'(out_log.size()), 64'd4);
    check("t3_log3", 64'(out_log[3]), 64'h14003);

    // 4: granted requester 1 stalls mid-frame while requester 0 waits
    out_log.delete();
    add_frame(0, 2, 8'h50);
    add_frame(1, 3, 8'h60);
    refresh();
    tick();
    check("t4_gnt1", 64'(in_rd), 64'h2);
    tick();
    hold[1] = 1'b1;
    refresh();
    #1;
    check("t4_gap0", 64'(in_rd), 64'h0);
    for (int g = 0; g < 3; g++) begin
      tick();
      check("t4_gap", 64'(in_rd), 64'h0);
    end
    hold[1] = 1'b0;
    refresh();
    #1;
    check("t4_resume", 64'(in_rd), 64'h2);
    drain(30, cyc);
    check("t4_log_n", 64'(out_log.size()), 64'd5);
    check("t4_log2", 64'(out_log[2]), 64'h16002);
    check("t4_log3", 64'(out_log[3]), 64'h05000);

    // 5: read of empty buffer, then frame counter wrap
    do_reset();
    tick();
    check("t5_err_clear", 64'(rd_err), 64'h0);
    out_rd = 1'b1;
    refresh();
    tick();
    out_rd = 1'b0;
    refresh();
    check("t5_err_set", 64'(rd_err), 64'h1);
    check("t5_still_empty", 64'(out_empty), 64'h1);
    tick();
    tick();
    check("t5_err_sticky", 64'(rd_err), 64'h1);
    out_rd = 1'b1;
    for (int f = 0; f < 15; f++) add_frame(0, 1, 8'(8'h90 + f));
    refresh();
    drain(100, cyc);
    check("t5_frm15", 64'(frm_cnt[CNT_W-1:0]), 64'hf);
    add_frame(0, 1, 8'hAF);
    refresh();
    drain(20, cyc);
    check("t5_wrap", 64'(frm_cnt[CNT_W-1:0]), 64'h0);

    // 6: asynchronous reset mid-frame with a full buffer
    do_reset();
    add_frame(1, 4, 8'h70);
    refresh();
    tick();
    tick();
    tick();
    check("t6_full", 64'(out_aempty), 64'h0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_empty", 64'(out_empty), 64'h1);
    check("t6_rst_aempty", 64'(out_aempty), 64'h1);
    check("t6_rst_data", 64'(out_data), 64'h0);
    check("t6_rst_tlast", 64'(out_tlast), 64'h0);
    check("t6_rst_in_rd", 64'(in_rd), 64'h0);
    check("t6_rst_frm", 64'(frm_cnt), 64'h0);
    reset_src();
    refresh();
    tick();
    rst = 1'b0;
    refresh();
    out_log.delete();
    add_frame(0, 1, 8'h80);
    add_frame(1, 1, 8'h81);
    out_rd = 1'b1;
    refresh();
    drain(20, cyc);
    check("t6_log_n", 64'(out_log.size()), 64'd2);
    check("t6_first_req0", 64'(out_log[0]), 64'h18000);
    check("t6_then_req1", 64'(out_log[1]), 64'h18100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
